keypad_encoder_p: RTL and testbench
===================================

KEYPAD_ENCODER_P -- requirements
Module: keypad_encoder_p

Interface
REQ-001 The block SHALL take parameter NUM_KEYS, default 10: number of keypad lines; legal range 2..16.
REQ-002 The block SHALL take parameter D_W, default 4: code width; D_W >= ceil(log2(NUM_KEYS)).
REQ-003 The block SHALL take parameter DB_CYCLES, default 4: consecutive stable cycles required for press and for release; legal range 1..255.
REQ-004 The block SHALL take parameter DIV, default 100: period in cycles of the divided tick; legal range 2..1023.
REQ-005 The block SHALL take parameter RPT_DELAY, default 50: hold cycles before first auto-repeat.
REQ-006 The block SHALL take parameter RPT_RATE, default 10: cycles between subsequent auto-repeats.
REQ-007 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-008 The block SHALL have port rstn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-009 The block SHALL have port key, input, NUM_KEYS bits: raw keypad lines, active-high, bit i = digit i.
REQ-010 The block SHALL have port enbn, input, 1 bit: active-low encoder enable, also the pgt source select.
REQ-011 The block SHALL have port rpt_en, input, 1 bit: auto-repeat mode enable.
REQ-012 The block SHALL have port D, output, D_W bits: registered index of the accepted key.
REQ-013 The block SHALL have port loadn, output, 1 bit: active-low, one-cycle strobe marking D valid.
REQ-014 The block SHALL have port pgt, output, 1 bit: debounced strobe or divided tick.
REQ-015 The block SHALL have port multi, output, 1 bit: high while more than one key line is asserted and enbn=0.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, BOUNCE, HELD and RELEASE.
REQ-017 In IDLE, enbn=0 with exactly one key bit high SHALL capture that index into cand, clear the stability counter and go to BOUNCE.
REQ-018 In BOUNCE, key equal to onehot(cand) for DB_CYCLES consecutive cycles SHALL load D<=cand, pulse loadn low for 1 cycle and go to HELD; any other key value SHALL return the FSM to IDLE with no strobe.
REQ-019 Latency SHALL be fixed: with key stable from cycle 0, the FSM enters BOUNCE at edge 1 and loadn is low during cycle DB_CYCLES+1.
REQ-020 In HELD, key==0 SHALL move the FSM to RELEASE; if rpt_en=1, a strobe SHALL fire after RPT_DELAY held cycles and then every RPT_RATE cycles with D unchanged; rpt_en=0 SHALL give no repeats.
REQ-021 In HELD, a key value other than onehot(D) or 0 (a second key or a roll-over) SHALL hold the state and suppress repeats; no new code SHALL be accepted until a full release.
REQ-022 In RELEASE, key==0 for DB_CYCLES consecutive cycles SHALL move the FSM to IDLE; any nonzero key SHALL restart the count; no strobe is issued on release.
REQ-023 multi SHALL be combinational: popcount(key)>1 AND enbn=0; multi=1 SHALL block the IDLE->BOUNCE transition.
REQ-024 enbn=1 SHALL force the FSM to IDLE on the next edge, suppress loadn, and hold D.
REQ-025 A free-running divider (0..DIV-1, wrapping) SHALL produce tick=1 for one cycle when the count equals DIV-1, independent of enbn.
REQ-026 pgt SHALL equal ~loadn when enbn=0 and tick when enbn=1; the select is combinational on enbn.
REQ-027 All counters SHALL be sized for their maximum value plus 1 and SHALL saturate rather than wrap; D SHALL be zero-extended to D_W.

Reset
REQ-028 While rstn=0, the block SHALL set FSM=IDLE, D=0, loadn=1, divider=0 and all counters=0; pgt SHALL be 0 when enbn=0.
REQ-029 rstn assertion mid-BOUNCE or mid-HELD SHALL abort with no strobe; after release, a key still held SHALL be re-debounced from IDLE.

Verification
REQ-030 The bench SHALL apply: defaults, enbn=0, key=10'b0000001000 held for 10 cycles -> one loadn low pulse in cycle 5, D=3, pgt=1 in the same cycle, then silence.
REQ-031 The bench SHALL apply: key bit 7 toggling every 2 cycles (DB_CYCLES=4) -> no loadn, FSM toggles IDLE/BOUNCE, D unchanged.
REQ-032 The bench SHALL apply: rpt_en=1, key bit 9 held for 80 cycles -> strobes at cycles 5, 55, 65 and 75, all with D=9.
REQ-033 The bench SHALL apply: keys 2 and 5 pressed together -> multi=1, no loadn; releasing key 5 -> key 2 accepted, D=2.
REQ-034 The bench SHALL apply: enbn=1 for 300 cycles -> pgt pulses every 100 cycles, loadn stays 1, keys ignored.
REQ-035 The bench SHALL apply: rstn pulsed low during HELD with the key still down -> outputs at reset values, then one new strobe DB_CYCLES+1 cycles after rstn rises.

Source files
------------

// File: rtl/keypad_encoder_p.sv
// keypad_encoder_p
//   Debounced priority-free keypad encoder with optional auto-repeat and a
//   free-running divided tick.
//
// Ports
//   clk     in   single clock, rising edge
//   rstn    in   asynchronous active-low reset
//   key     in   [NUM_KEYS] raw keypad lines, active-high, bit i = digit i
//   enbn    in   active-low encoder enable; also selects the pgt source
//   rpt_en  in   auto-repeat mode enable
//   D       out  [D_W] registered index of the accepted key
//   loadn   out  active-low one-cycle strobe marking D valid
//   pgt     out  ~loadn when enbn=0, divided tick when enbn=1
//   multi   out  more than one key line asserted while enabled
module keypad_encoder_p #(
  parameter int unsigned NUM_KEYS  = 10,
  parameter int unsigned D_W       = 4,
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned DIV       = 100,
  parameter int unsigned RPT_DELAY = 50,
  parameter int unsigned RPT_RATE  = 10
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                enbn,
  input  logic                rpt_en,
  output logic [D_W-1:0]      D,
  output logic                loadn,
  output logic                pgt,
  output logic                multi
);

  localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);
  localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam int unsigned DIV_W   = $clog2(DIV + 1);
  localparam int unsigned PC_W    = $clog2(NUM_KEYS + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_SAT     = DB_W'(DB_CYCLES);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(RPT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(RPT_RATE - 1);
  localparam logic [RPT_W-1:0] RPT_SAT    = RPT_W'(RPT_MAX);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    HELD,
    RELEASE
  } state_t;

  state_t              state;
  logic [D_W-1:0]      cand;
  logic [DB_W-1:0]     db_cnt;
  logic [RPT_W-1:0]    rpt_cnt;
  logic                rpt_phase;   // 0: waiting initial delay, 1: repeating at rate
  logic [DIV_W-1:0]    div_cnt;

  logic [PC_W-1:0]     pop;
  logic [D_W-1:0]      idx;
  logic                one_hot;
  logic                tick;
  logic [NUM_KEYS-1:0] cand_oh;
  logic [NUM_KEYS-1:0] d_oh;

  // Population count and index of the (last) set line; idx is only used
  // when exactly one line is set, so which set bit wins does not matter.
  always_comb begin
    pop = '0;
    idx = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (key[i]) begin
        pop = pop + PC_W'(1);
        idx = D_W'(i);
      end
    end
  end

  assign one_hot = (pop == PC_W'(1));
  assign multi   = (pop > PC_W'(1)) && !enbn;
  assign cand_oh = NUM_KEYS'(1) << cand;
  assign d_oh    = NUM_KEYS'(1) << D;
  assign tick    = (div_cnt == DIV_LAST);
  assign pgt     = enbn ? tick : ~loadn;

  // Free-running divider, independent of enbn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cand      <= '0;
      D         <= '0;
      loadn     <= 1'b1;
      db_cnt    <= '0;
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else begin
      loadn <= 1'b1;
      if (enbn) begin
        state     <= IDLE;
        db_cnt    <= '0;
        rpt_cnt   <= '0;
        rpt_phase <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (one_hot && !multi) begin
              cand   <= idx;
              db_cnt <= '0;
              state  <= BOUNCE;
            end
          end
          BOUNCE: begin
            if (key == cand_oh) begin
              if (db_cnt == DB_LAST) begin
                D         <= cand;
                loadn     <= 1'b0;
                rpt_cnt   <= '0;
                rpt_phase <= 1'b0;
                state     <= HELD;
              end else if (db_cnt != DB_SAT) begin
                db_cnt <= db_cnt + DB_W'(1);
              end
            end else begin
              state <= IDLE;
            end
          end
          HELD: begin
            if (key == '0) begin
              db_cnt <= '0;
              state  <= RELEASE;
            end else if (key != d_oh || !rpt_en) begin
              // Roll-over or repeat disabled: no repeats, and the initial
              // delay restarts once the original key is alone again.
              rpt_cnt   <= '0;
              rpt_phase <= 1'b0;
            end else if (rpt_cnt == (rpt_phase ? RATE_LAST : DELAY_LAST)) begin
              loadn     <= 1'b0;
              rpt_cnt   <= '0;
              rpt_phase <= 1'b1;
            end else if (rpt_cnt != RPT_SAT) begin
              rpt_cnt <= rpt_cnt + RPT_W'(1);
            end
          end
          RELEASE: begin
            if (key != '0) begin
              db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
              state <= IDLE;
            end else if (db_cnt != DB_SAT) begin
              db_cnt <= db_cnt + DB_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_encoder_p.sv
module tb_keypad_encoder_p;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [9:0] key = '0;
  logic       enbn = 1'b0;
  logic       rpt_en = 1'b0;
  logic [3:0] D;
  logic       loadn;
  logic       pgt;
  logic       multi;

  always #5 clk = ~clk;

  keypad_encoder_p #(
    .NUM_KEYS (10),
    .D_W      (4),
    .DB_CYCLES(4),
    .DIV      (100),
    .RPT_DELAY(50),
    .RPT_RATE (10)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .key   (key),
    .enbn  (enbn),
    .rpt_en(rpt_en),
    .D     (D),
    .loadn (loadn),
    .pgt   (pgt),
    .multi (multi)
  );

  typedef struct {
    int cyc;
    int d;
  } exp_t;

  typedef struct {
    logic [9:0] key;
    logic       enbn;
    logic       exp_multi;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_strobe(input int c, input int d);
    exp_t e;
    e.cyc = c;
    e.d   = d;
    sb.push_back(e);
  endtask

  // Advance one clock; sample just after the edge and score any strobe.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (loadn == 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe_cycle", cyc, -1);
      end else begin
        e = sb.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("strobe_D", int'(D), e.d);
        check("strobe_pgt", int'(pgt), 1);
      end
    end
  endtask

  task automatic sb_done(input string name);
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  // Key applied during cycles 0..hold-1, then released for tail cycles.
  task automatic press(input logic [9:0] k, input int hold, input int tail);
    cyc = 0;
    key = k;
    repeat (hold) step();
    key = '0;
    repeat (tail) step();
  endtask

  initial begin
    #100us;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int last;
    int npulse;

    vecs = '{
      '{10'b0000000000, 1'b0, 1'b0},
      '{10'b0000001000, 1'b0, 1'b0},
      '{10'b0000100100, 1'b0, 1'b1},
      '{10'b1000000001, 1'b0, 1'b1},
      '{10'b1111111111, 1'b0, 1'b1},
      '{10'b0000100100, 1'b1, 1'b0},
      '{10'b1000000000, 1'b0, 1'b0},
      '{10'b0001110000, 1'b0, 1'b1}
    };

    // Combinational multi checks while the FSM is held in reset.
    #1;
    for (int i = 0; i < 8; i++) begin
      key  = vecs[i].key;
      enbn = vecs[i].enbn;
      #1;
      check($sformatf("multi_vec%0d", i), int'(multi), int'(vecs[i].exp_multi));
    end
    key  = '0;
    enbn = 1'b0;
    #1;
    check("reset_D", int'(D), 0);
    check("reset_loadn", int'(loadn), 1);
    check("reset_pgt", int'(pgt), 0);
    check("reset_multi", int'(multi), 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) step();

    // Single key 3 held 10 cycles: one strobe in cycle 5.
    expect_strobe(5, 3);
    press(10'b0000001000, 10, 12);
    sb_done("s1_queue_empty");

    // Key 7 bouncing every 2 cycles: never accepted.
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      key = (i % 2 == 0) ? 10'b0010000000 : 10'b0000000000;
      step();
      step();
    end
    key = '0;
    repeat (4) step();
    sb_done("s2_queue_empty");
    check("s2_D_unchanged", int'(D), 3);

    // Auto-repeat on key 9 held 80 cycles.
    rpt_en = 1'b1;
    expect_strobe(5, 9);
    expect_strobe(55, 9);
    expect_strobe(65, 9);
    expect_strobe(75, 9);
    press(10'b1000000000, 80, 15);
    rpt_en = 1'b0;
    sb_done("s3_queue_empty");

    // Keys 2+5 together, then key 5 released: key 2 accepted.
    cyc = 0;
    key = 10'b0000100100;
    #1;
    check("s4_multi_both", int'(multi), 1);
    repeat (6) step();
    check("s4_multi_held", int'(multi), 1);
    key = 10'b0000000100;
    #1;
    check("s4_multi_single", int'(multi), 0);
    expect_strobe(11, 2);
    repeat (14) step();
    // Release glitch shorter than the debounce window: no new strobe.
    key = '0;
    repeat (2) step();
    key = 10'b0000000100;
    repeat (10) step();
    key = '0;
    repeat (10) step();
    sb_done("s4_queue_empty");
    check("s4_D", int'(D), 2);

    // Disabled: pgt is the divided tick, keys ignored.
    enbn   = 1'b1;
    key    = 10'b0000010000;
    last   = -1;
    npulse = 0;
    cyc    = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (pgt) begin
        if (last >= 0) check("tick_interval", cyc - last, 100);
        last = cyc;
        npulse++;
      end
    end
    check("tick_count", npulse, 3);
    key  = '0;
    enbn = 1'b0;
    repeat (5) step();
    sb_done("s5_queue_empty");
    check("s5_D_held", int'(D), 2);

    // Reset during HELD with key still down, then re-debounce.
    cyc = 0;
    key = 10'b0001000000;
    expect_strobe(5, 6);
    repeat (10) step();
    rstn = 1'b0;
    #1;
    check("s6_rst_D", int'(D), 0);
    check("s6_rst_loadn", int'(loadn), 1);
    check("s6_rst_pgt", int'(pgt), 0);
    repeat (2) step();
    rstn = 1'b1;
    expect_strobe(17, 6);
    repeat (13) step();
    key = '0;
    repeat (10) step();
    sb_done("s6_queue_empty");
    check("s6_D", int'(D), 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
